// File: rtl/disp_pkg.sv
// Shared types and constants for the two-digit multiplexed 7-segment display.
// Segment patterns are active-low, bit 0 = segment a through bit 6 = segment g.
package disp_pkg;

  typedef enum logic [1:0] {
    SHOW_U  = 2'd0,
    BLANK_U = 2'd1,
    SHOW_T  = 2'd2,
    BLANK_T = 2'd3
  } scan_state_t;

  localparam logic [6:0] SEG_OFF = 7'h7F;

  // Entry [d] is the pattern for digit d, so digit 9 leads the concatenation.
  localparam logic [9:0][6:0] SEG_LUT = {
    7'h10, 7'h00, 7'h78, 7'h02, 7'h12,
    7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

endpackage

// File: rtl/seg7_enc.sv
// Combinational digit to active-low 7-segment encoder.
// Codes above 9 have no glyph and drive every segment off.
module seg7_enc
  import disp_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_OFF;
    if (digit <= 4'd9) begin
      seg = SEG_LUT[digit];
    end
  end

endmodule

// File: rtl/disp2_scan_ctrl.sv
// Two-digit time-multiplexed 7-segment scan controller with a one-entry load slot.
// The shown value changes only at frame boundaries, so a digit pair never mixes two values.
module disp2_scan_ctrl
  import disp_pkg::*;
#(
  parameter int DWELL_CYCLES = 50000,
  parameter int BLANK_CYCLES = 500,
  parameter int LZ_BLANK     = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       load_valid,
  input  logic [3:0] load_data,
  output logic       load_ready,
  output logic [6:0] seg,
  output logic       anode0,
  output logic       anode1,
  output logic       frame_done
);

  localparam int CNT_MAX = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);

  scan_state_t      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       disp_val_q, disp_val_d;
  logic [3:0]       pend_val_q, pend_val_d;
  logic             pend_full_q, pend_full_d;

  logic             slot_last;
  logic [3:0]       tens, units, digit;
  logic [6:0]       digit_seg;
  logic             lit;

  // Handshake: a value transfers on any rising edge where load_valid and
  // load_ready are both high; load_ready depends only on the holding slot.
  assign load_ready = ~pend_full_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    disp_val_d  = disp_val_q;
    pend_val_d  = pend_val_q;
    pend_full_d = pend_full_q;
    frame_done  = 1'b0;

    if ((state_q == SHOW_U) || (state_q == SHOW_T)) begin
      slot_last = (cnt_q == DWELL_LAST);
    end else begin
      slot_last = (cnt_q == BLANK_LAST);
    end

    if (load_valid && load_ready) begin
      pend_val_d  = load_data;
      pend_full_d = 1'b1;
    end

    if (en) begin
      if (slot_last) begin
        cnt_d = '0;
        case (state_q)
          SHOW_U:  state_d = BLANK_U;
          BLANK_U: state_d = SHOW_T;
          SHOW_T:  state_d = BLANK_T;
          default: state_d = SHOW_U;
        endcase
        // Frame boundary: the only point where the shown value may change.
        if (state_q == BLANK_T) begin
          frame_done = 1'b1;
          if (pend_full_q) begin
            disp_val_d  = pend_val_q;
            pend_full_d = 1'b0;
          end
        end
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= SHOW_U;
      cnt_q       <= '0;
      disp_val_q  <= 4'd0;
      pend_val_q  <= 4'd0;
      pend_full_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      disp_val_q  <= disp_val_d;
      pend_val_q  <= pend_val_d;
      pend_full_q <= pend_full_d;
    end
  end

  always_comb begin
    tens  = {3'b000, (disp_val_q >= 4'd10)};
    units = (disp_val_q >= 4'd10) ? (disp_val_q - 4'd10) : disp_val_q;
    digit = (state_q == SHOW_T) ? tens : units;
  end

  seg7_enc u_seg7_enc (
    .digit (digit),
    .seg   (digit_seg)
  );

  // Reset forces the pins dark straight away instead of waiting for state to settle.
  assign lit = en & rst_n;

  always_comb begin
    seg    = SEG_OFF;
    anode0 = 1'b1;
    anode1 = 1'b1;
    if (lit) begin
      case (state_q)
        SHOW_U: begin
          anode0 = 1'b0;
          seg    = digit_seg;
        end
        SHOW_T: begin
          if (!((LZ_BLANK != 0) && (tens == 4'd0))) begin
            anode1 = 1'b0;
            seg    = digit_seg;
          end
        end
        default: begin
          seg = SEG_OFF;
        end
      endcase
    end
  end

endmodule

// File: doc/disp2_scan_ctrl.md
Name: disp2_scan_ctrl

Overview:
- Time-multiplexed scan controller for the two-digit 7-segment display: one shared segment bus, two anode enables (units, tens).
- Accepts a 4-bit binary value (0..15) through a valid/ready handshake and splits it into tens/units.
- Alternates the digits with a programmable dwell and a blanking gap, which prevents ghosting when the anode switches.
- Sits between the user/datapath logic that produces the count and the board display pins.

Parameters:
- DWELL_CYCLES, 50000, clock cycles each digit is lit per scan slot (>=1).
- BLANK_CYCLES, 500, clock cycles all anodes are off between digits (>=1).
- LZ_BLANK, 1, 1 = tens digit suppressed (anode kept off) when tens==0.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- en  in  1  scan enable; 0 = display dark, FSM frozen
- load_valid  in  1  new value offered
- load_data  in  4  binary value 0..15
- load_ready  out  1  pending slot free, transfer accepted when load_valid&load_ready
- seg  out  7  segments, active-low, seg[0]=a .. seg[6]=g
- anode0  out  1  units digit enable, active-low
- anode1  out  1  tens digit enable, active-low
- frame_done  out  1  one-cycle pulse at end of each full scan frame

Behaviour:
- Reset (async assert, sync release):
  - state=SHOW_U, cnt=0, disp_val=0, pend_full=0.
  - Outputs: seg=7'h7F, anode0=1, anode1=1, load_ready=1, frame_done=0.
- Registers:
  - disp_val[3:0] is the displayed value; pend_val[3:0] with pend_full is a one-entry holding slot.
  - cnt is the dwell/blank counter, width $clog2(max(DWELL_CYCLES,BLANK_CYCLES)+1).
- Split: tens = (disp_val>=10); units = tens ? disp_val-10 : disp_val. Both are 4-bit; the subtraction never underflows.
- FSM states: SHOW_U -> BLANK_U -> SHOW_T -> BLANK_T -> SHOW_U.
  - SHOW_x lasts DWELL_CYCLES cycles and BLANK_x lasts BLANK_CYCLES cycles.
  - cnt counts 0..N-1. On cnt==N-1 the state advances and cnt clears.
- Outputs are decoded combinationally from registered state and disp_val only (no path from load_* to seg/anode):
  - SHOW_U: anode0=0, anode1=1, seg=enc(units).
  - SHOW_T: anode1=0, anode0=1, seg=enc(tens). If LZ_BLANK and tens==0, then anode1=1 and seg=7'h7F.
  - BLANK_x: both anodes 1, seg=7'h7F.
- Encoding enc(d), active-low, for d=0..9: 0=7'h40, 1=7'h79, 2=7'h24, 3=7'h30, 4=7'h19, 5=7'h12, 6=7'h02, 7=7'h78, 8=7'h00, 9=7'h10.
- Load handshake:
  - load_ready = ~pend_full.
  - On a transfer: pend_val<=load_data, pend_full<=1.
  - load_data values 10..15 are legal. No value is illegal (the 4-bit range covers at most 15).
- Frame boundary (last cycle of BLANK_T with en=1):
  - frame_done=1 for that cycle.
  - If pend_full: disp_val<=pend_val and pend_full<=0.
  - A handshake in that same cycle cannot occur because load_ready=0 while pend_full. When pend_full=0 the new load lands in pend and is shown at the next boundary.
- Tear-free rule: disp_val changes only at a frame boundary, so a digit pair is never mixed across values.
- en=0:
  - State and cnt hold; both anodes 1; seg=7'h7F; frame_done=0.
  - The handshake still operates (a load can fill pend).
  - On en returning to 1, scanning resumes from the held state/cnt.
- Reset mid-frame: everything returns to reset values immediately, asynchronously, and any pending value is discarded.
- Both anodes are never low in the same cycle in any state.

Decomposition:
- Package disp_pkg:
  - typedef enum logic [1:0] scan_state_t {SHOW_U, BLANK_U, SHOW_T, BLANK_T}.
  - localparam SEG_OFF = 7'h7F.
  - The SEG_LUT constant array for digits 0..9.
- Sub-module seg7_enc (combinational 4-bit digit to active-low 7-bit seg via SEG_LUT). Inputs above 9 produce SEG_OFF.
- The controller instantiates seg7_enc once on the muxed digit.

Test Plan (DWELL_CYCLES=4, BLANK_CYCLES=2, LZ_BLANK=1):
- Reset then en=1, no load:
  - units shows 0: anode0=0 and seg=7'h40 for 4 cycles, then all off for 2 cycles.
  - tens is suppressed (anode1 stays 1).
  - frame_done pulses every 12 cycles.
- Load 13 mid-frame:
  - load_ready falls the next cycle; display is unchanged until the frame boundary.
  - Next frame: units seg=7'h30 (3), tens anode1=0 with seg=7'h79 (1). load_ready rises after the boundary.
- Load 10 then 7 back-to-back:
  - 7 is held off (load_ready=0) until the boundary consumes 10.
  - The following frame shows 10 (units 7'h40, tens 7'h79); 7 is shown one frame later with tens blank.
- en dropped for 5 cycles during SHOW_T:
  - Both anodes 1 and seg=7'h7F while en=0; cnt is frozen.
  - SHOW_T completes its remaining cycles after en returns.
- rst_n asserted during SHOW_T with pend_full=1:
  - Outputs go to reset values in the same cycle.
  - After release, 0 is displayed and load_ready=1.
- Check on every cycle of the whole run: never both anode0=0 and anode1=0, and seg=7'h7F whenever both anodes are 1.
